// File: rtl/udp_recv_if.sv
// rtl/udp_recv_if.sv - IP-payload input and UDP-payload output bundle for udp_recv
interface udp_recv_if;
    logic [7:0]  ip_rx_data;
    logic        ip_rx_active;
    logic [7:0]  ip_protocol;
    logic        ip_broadcast;
    logic [31:0] ip_src_addr;
    logic [31:0] ip_dst_addr;

    logic [7:0]  udp_rx_data;
    logic        udp_rx_active;
    logic [15:0] to_port;
    logic [15:0] from_port;
    logic [15:0] udp_length;
    logic        broadcast;
    logic        len_err;
    logic        trunc_err;
    logic        csum_err;
    logic [15:0] udp_pkt_count;

    modport master (
        output ip_rx_data, ip_rx_active, ip_protocol, ip_broadcast, ip_src_addr, ip_dst_addr,
        input  udp_rx_data, udp_rx_active, to_port, from_port, udp_length, broadcast,
               len_err, trunc_err, csum_err, udp_pkt_count
    );

    modport slave (
        input  ip_rx_data, ip_rx_active, ip_protocol, ip_broadcast, ip_src_addr, ip_dst_addr,
        output udp_rx_data, udp_rx_active, to_port, from_port, udp_length, broadcast,
               len_err, trunc_err, csum_err, udp_pkt_count
    );
endinterface

// File: rtl/udp_recv.sv
// rtl/udp_recv.sv - strips and validates the UDP header, forwards payload bytes to port handlers
// Optional checksum verification enabled by defining UDP_CHECKSUM_EN.
module udp_recv #(
    parameter int         MAX_UDP_LEN  = 1500,
    parameter logic [7:0] UDP_PROTOCOL = 8'd17
) (
    input  logic      rx_clock,
    input  logic      reset_n,
    udp_recv_if.slave bus
);
    localparam logic [15:0] LP_MAX_LEN = 16'(MAX_UDP_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_DRAIN} state_t;

    state_t      r_state;
    logic [2:0]  r_byte_cnt;
    logic [15:0] r_remain;
    logic [7:0]  r_udp_rx_data;
    logic        r_udp_rx_active;
    logic [15:0] r_to_port;
    logic [15:0] r_from_port;
    logic [15:0] r_udp_length;
    logic        r_broadcast;
    logic        r_len_err;
    logic        r_trunc_err;
    logic [15:0] r_udp_pkt_count;

    logic w_len_bad;
    assign w_len_bad = (r_udp_length < 16'd8) || (r_udp_length > LP_MAX_LEN);

    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_byte_cnt      <= 3'd0;
            r_remain        <= 16'd0;
            r_udp_rx_data   <= 8'd0;
            r_udp_rx_active <= 1'b0;
            r_to_port       <= 16'd0;
            r_from_port     <= 16'd0;
            r_udp_length    <= 16'd0;
            r_broadcast     <= 1'b0;
            r_len_err       <= 1'b0;
            r_trunc_err     <= 1'b0;
            r_udp_pkt_count <= 16'd0;
        end else begin
            r_len_err       <= 1'b0;
            r_trunc_err     <= 1'b0;
            r_udp_rx_active <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.ip_rx_active) begin
                        if (bus.ip_protocol == UDP_PROTOCOL) begin
                            r_from_port[15:8] <= bus.ip_rx_data;
                            r_broadcast       <= bus.ip_broadcast;
                            r_byte_cnt        <= 3'd1;
                            r_state           <= ST_HDR;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_HDR: begin
                    if (!bus.ip_rx_active) begin
                        r_trunc_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        case (r_byte_cnt)
                            3'd1: r_from_port[7:0]   <= bus.ip_rx_data;
                            3'd2: r_to_port[15:8]    <= bus.ip_rx_data;
                            3'd3: r_to_port[7:0]     <= bus.ip_rx_data;
                            3'd4: r_udp_length[15:8] <= bus.ip_rx_data;
                            3'd5: r_udp_length[7:0]  <= bus.ip_rx_data;
                            3'd7: begin
                                // Length is fully registered by now; checksum bytes 6/7 don't affect routing.
                                if (w_len_bad) begin
                                    r_len_err <= 1'b1;
                                    r_state   <= ST_DRAIN;
                                end else if (r_udp_length == 16'd8) begin
                                    r_udp_pkt_count <= r_udp_pkt_count + 16'd1;
                                    r_state         <= ST_DRAIN;
                                end else begin
                                    r_remain <= r_udp_length - 16'd8;
                                    r_state  <= ST_PAYLOAD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (!bus.ip_rx_active) begin
                        r_trunc_err <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_udp_rx_data   <= bus.ip_rx_data;
                        r_udp_rx_active <= 1'b1;
                        r_remain        <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_udp_pkt_count <= r_udp_pkt_count + 16'd1;
                            r_state         <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!bus.ip_rx_active) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.udp_rx_data   = r_udp_rx_data;
    assign bus.udp_rx_active = r_udp_rx_active;
    assign bus.to_port       = r_to_port;
    assign bus.from_port     = r_from_port;
    assign bus.udp_length    = r_udp_length;
    assign bus.broadcast     = r_broadcast;
    assign bus.len_err       = r_len_err;
    assign bus.trunc_err     = r_trunc_err;
    assign bus.udp_pkt_count = r_udp_pkt_count;

`ifdef UDP_CHECKSUM_EN
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    logic [15:0] r_sum;
    logic [15:0] r_csum_rx;
    logic [7:0]  r_hi;
    logic        r_odd;
    logic        r_csum_chk;
    logic        r_csum_err;
    logic [15:0] w_pseudo;

    // Pseudo-header minus length; length is folded in twice when its header word arrives.
    assign w_pseudo = oc_add(oc_add(oc_add(bus.ip_src_addr[31:16], bus.ip_src_addr[15:0]),
                                    oc_add(bus.ip_dst_addr[31:16], bus.ip_dst_addr[15:0])),
                             {8'd0, bus.ip_protocol});

    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum      <= 16'd0;
            r_csum_rx  <= 16'd0;
            r_hi       <= 8'd0;
            r_odd      <= 1'b0;
            r_csum_chk <= 1'b0;
            r_csum_err <= 1'b0;
        end else begin
            r_csum_chk <= 1'b0;
            r_csum_err <= r_csum_chk && (r_csum_rx != 16'd0) && (r_sum != 16'hFFFF);
            case (r_state)
                ST_IDLE: begin
                    r_sum <= w_pseudo;
                    r_odd <= 1'b0;
                end
                ST_HDR: begin
                    if (bus.ip_rx_active) begin
                        case (r_byte_cnt)
                            3'd1: r_sum <= oc_add(r_sum, {r_from_port[15:8], bus.ip_rx_data});
                            3'd3: r_sum <= oc_add(r_sum, {r_to_port[15:8], bus.ip_rx_data});
                            3'd5: r_sum <= oc_add(oc_add(r_sum, {r_udp_length[15:8], bus.ip_rx_data}),
                                                  {r_udp_length[15:8], bus.ip_rx_data});
                            3'd6: r_csum_rx[15:8] <= bus.ip_rx_data;
                            3'd7: begin
                                r_sum          <= oc_add(r_sum, {r_csum_rx[15:8], bus.ip_rx_data});
                                r_csum_rx[7:0] <= bus.ip_rx_data;
                                r_csum_chk     <= (r_udp_length == 16'd8);
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (bus.ip_rx_active) begin
                        r_odd      <= ~r_odd;
                        r_csum_chk <= (r_remain == 16'd1);
                        if (r_odd)
                            r_sum <= oc_add(r_sum, {r_hi, bus.ip_rx_data});
                        else if (r_remain == 16'd1)
                            r_sum <= oc_add(r_sum, {bus.ip_rx_data, 8'h00});
                        else
                            r_hi <= bus.ip_rx_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.csum_err = r_csum_err;
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.ip_src_addr, bus.ip_dst_addr};
    assign bus.csum_err  = 1'b0;
`endif
endmodule

// File: tb/tb_udp_recv.sv
// tb/tb_udp_recv.sv - randomized self-checking bench for udp_recv against a datagram-level model
module tb_udp_recv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    udp_recv_if u_if();

    udp_recv #(.MAX_UDP_LEN(1500), .UDP_PROTOCOL(8'd17)) dut (
        .rx_clock (clk),
        .reset_n  (rst_n),
        .bus      (u_if)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    // monitor
    logic [7:0]  got_q[$];
    int          rises, len_pulses, trunc_pulses, csum_pulses, bcast_hits;
    int          first_out_cyc, last_out_cyc, trunc_cyc, csum_cyc, drv_cyc;
    logic [15:0] first_to, first_from;
    logic        prev_act = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.udp_rx_active) begin
                got_q.push_back(u_if.udp_rx_data);
                if (!prev_act) begin
                    rises++;
                    first_to   = u_if.to_port;
                    first_from = u_if.from_port;
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                end
                last_out_cyc = cyc;
                if (u_if.broadcast) bcast_hits++;
            end
            if (u_if.len_err) len_pulses++;
            if (u_if.trunc_err) begin trunc_pulses++; trunc_cyc = cyc; end
            if (u_if.csum_err) begin csum_pulses++; csum_cyc = cyc; end
        end
        prev_act = u_if.udp_rx_active;
    end

    // stimulus and reference model
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] src_addr, dst_addr;
    int          e_len, e_trunc, e_done, e_csum;
    logic [15:0] exp_count = 16'd0;

    function automatic logic [15:0] csum_total(input int len);
        longint s;
        logic [7:0] lo;
        s = src_addr[31:16] + src_addr[15:0] + dst_addr[31:16] + dst_addr[15:0] + 17 + len;
        for (int i = 0; i < len; i += 2) begin
            lo = (i + 1 < len) ? tx_q[i+1] : 8'h00;
            s += {tx_q[i], lo};
        end
        while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                         input int nbytes, input bit incr, input bit fix_csum);
        logic [15:0] c;
        tx_q = {};
        tx_q.push_back(sp[15:8]); tx_q.push_back(sp[7:0]);
        tx_q.push_back(dp[15:8]); tx_q.push_back(dp[7:0]);
        tx_q.push_back(len[15:8]); tx_q.push_back(len[7:0]);
        tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        for (int i = 8; i < nbytes; i++) tx_q.push_back(incr ? 8'(i - 8) : 8'($urandom));
        if (fix_csum) begin
            c = ~csum_total(int'(len));
            if (c == 16'h0000) c = 16'hFFFF;
            tx_q[6] = c[15:8];
            tx_q[7] = c[7:0];
        end
    endtask

    task automatic model(input logic [7:0] proto, input int ip_len);
        int len;
        exp_q = {}; e_len = 0; e_trunc = 0; e_done = 0; e_csum = 0;
        if (proto != 8'd17 || ip_len == 0) return;
        if (ip_len < 8) begin e_trunc = 1; return; end
        len = {tx_q[4], tx_q[5]};
        if (len < 8 || len > 1500) begin e_len = 1; return; end
        if (ip_len < len) begin
            e_trunc = 1;
            for (int i = 8; i < ip_len; i++) exp_q.push_back(tx_q[i]);
        end else begin
            e_done = 1;
            for (int i = 8; i < len; i++) exp_q.push_back(tx_q[i]);
`ifdef UDP_CHECKSUM_EN
            e_csum = ({tx_q[6], tx_q[7]} != 16'h0000 && csum_total(len) != 16'hFFFF) ? 1 : 0;
`endif
        end
        exp_count = exp_count + 16'(e_done);
    endtask

    task automatic send(input logic [7:0] proto, input bit bcast, input int ip_len);
        got_q = {}; rises = 0; len_pulses = 0; trunc_pulses = 0; csum_pulses = 0; bcast_hits = 0;
        first_out_cyc = -1; last_out_cyc = -1; trunc_cyc = -1; csum_cyc = -1; drv_cyc = -1;
        model(proto, ip_len);
        u_if.ip_protocol  = proto;
        u_if.ip_broadcast = bcast;
        u_if.ip_src_addr  = src_addr;
        u_if.ip_dst_addr  = dst_addr;
        for (int i = 0; i < ip_len; i++) begin
            @(posedge clk); #1;
            u_if.ip_rx_active = 1'b1;
            u_if.ip_rx_data   = (i < tx_q.size()) ? tx_q[i] : 8'($urandom);
            if (i == 8) drv_cyc = cyc;
        end
        @(posedge clk); #1;
        u_if.ip_rx_active = 1'b0;
        u_if.ip_rx_data   = 8'h00;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_vec++; if (u_if.udp_rx_active !== 1'b0) begin n_err++; $display("FAIL reset_active got %b exp 0", u_if.udp_rx_active); end
        n_vec++; if (u_if.udp_rx_data !== 8'd0) begin n_err++; $display("FAIL reset_data got %h exp 00", u_if.udp_rx_data); end
        n_vec++; if ({u_if.to_port, u_if.from_port, u_if.udp_length} !== 48'd0) begin n_err++; $display("FAIL reset_ports got %h exp 0", {u_if.to_port, u_if.from_port, u_if.udp_length}); end
        n_vec++; if (u_if.udp_pkt_count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", u_if.udp_pkt_count); end
        n_vec++; if ({u_if.broadcast, u_if.len_err, u_if.trunc_err, u_if.csum_err} !== 4'd0) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {u_if.broadcast, u_if.len_err, u_if.trunc_err, u_if.csum_err}); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        build(16'h1234, 16'd1024, 16'd68, 68, 1'b1, 1'b1);
        send(8'd17, 1'b0, 68);
        n_vec++; if (first_from !== 16'h1234) begin n_err++; $display("FAIL basic_from got %h exp 1234", first_from); end
        n_vec++; if (first_to !== 16'd1024) begin n_err++; $display("FAIL basic_to got %0d exp 1024", first_to); end
        n_vec++; if (u_if.udp_length !== 16'd68) begin n_err++; $display("FAIL basic_len got %0d exp 68", u_if.udp_length); end
        n_vec++; if (rises != 1 || got_q.size() != 60) begin n_err++; $display("FAIL basic_active rises %0d bytes %0d exp 1 60", rises, got_q.size()); end
        for (int i = 0; i < 60 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== 8'(i)) begin n_err++; $display("FAIL basic_data[%0d] got %h exp %h", i, got_q[i], 8'(i)); end
        end
        n_vec++; if (first_out_cyc != drv_cyc + 1) begin n_err++; $display("FAIL basic_latency got %0d exp %0d", first_out_cyc, drv_cyc + 1); end
        n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL basic_count got %0d exp %0d", u_if.udp_pkt_count, exp_count); end
    endtask

    task automatic test_padding;
        build(16'h0400, 16'd1025, 16'd20, 20, 1'b0, 1'b1);
        send(8'd17, 1'b0, 46);
        n_vec++; if (rises != 1 || got_q.size() != 12) begin n_err++; $display("FAIL pad_active rises %0d bytes %0d exp 1 12", rises, got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pad_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL pad_count got %0d exp %0d", u_if.udp_pkt_count, exp_count); end
    endtask

    task automatic test_len_err;
        logic [15:0] bad_len[2] = '{16'd6, 16'd1600};
        for (int k = 0; k < 2; k++) begin
            build(16'h1111, 16'd1024, bad_len[k], 30, 1'b0, 1'b0);
            send(8'd17, 1'b0, 30);
            n_vec++; if (len_pulses != 1) begin n_err++; $display("FAIL len_err_%0d pulses got %0d exp 1", bad_len[k], len_pulses); end
            n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL len_active_%0d bytes got %0d exp 0", bad_len[k], got_q.size()); end
            n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL len_count got %0d exp %0d", u_if.udp_pkt_count, exp_count); end
        end
    endtask

    task automatic test_trunc;
        build(16'h2222, 16'd1024, 16'd108, 108, 1'b0, 1'b1);
        send(8'd17, 1'b0, 18);
        n_vec++; if (trunc_pulses != 1) begin n_err++; $display("FAIL trunc_pulse got %0d exp 1", trunc_pulses); end
        n_vec++; if (got_q.size() != 10 || got_q != exp_q) begin n_err++; $display("FAIL trunc_bytes got %0d exp 10", got_q.size()); end
        n_vec++; if (trunc_cyc != last_out_cyc + 1) begin n_err++; $display("FAIL trunc_timing got %0d exp %0d", trunc_cyc, last_out_cyc + 1); end
        n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL trunc_count got %0d exp %0d", u_if.udp_pkt_count, exp_count); end
        build(16'h3333, 16'd1024, 16'd40, 40, 1'b0, 1'b1);
        send(8'd17, 1'b0, 40);
        n_vec++; if (got_q.size() != 32 || got_q != exp_q || trunc_pulses != 0) begin n_err++; $display("FAIL trunc_next bytes %0d trunc %0d exp 32 0", got_q.size(), trunc_pulses); end
        n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL trunc_next_count got %0d exp %0d", u_if.udp_pkt_count, exp_count); end
    endtask

    task automatic test_proto_bcast;
        logic [47:0] snap;
        logic [15:0] cnt0;
        snap = {u_if.to_port, u_if.from_port, u_if.udp_length};
        cnt0 = u_if.udp_pkt_count;
        build(16'hABCD, 16'h5555, 16'd30, 30, 1'b0, 1'b0);
        send(8'd6, 1'b1, 30);
        n_vec++; if ({u_if.to_port, u_if.from_port, u_if.udp_length} !== snap) begin n_err++; $display("FAIL tcp_ports got %h exp %h", {u_if.to_port, u_if.from_port, u_if.udp_length}, snap); end
        n_vec++; if (u_if.udp_pkt_count !== cnt0 || got_q.size() != 0 || len_pulses + trunc_pulses != 0) begin n_err++; $display("FAIL tcp_quiet count %0d bytes %0d errs %0d exp %0d 0 0", u_if.udp_pkt_count, got_q.size(), len_pulses + trunc_pulses, cnt0); end
        build(16'h0001, 16'd1024, 16'd30, 30, 1'b0, 1'b1);
        send(8'd17, 1'b1, 30);
        n_vec++; if (bcast_hits != 22 || got_q.size() != 22) begin n_err++; $display("FAIL bcast_hits got %0d of %0d exp 22", bcast_hits, got_q.size()); end
        build(16'h0001, 16'd1024, 16'd12, 12, 1'b0, 1'b1);
        send(8'd17, 1'b0, 12);
        n_vec++; if (bcast_hits != 0 || u_if.broadcast !== 1'b0) begin n_err++; $display("FAIL bcast_clear hits %0d flag %b exp 0 0", bcast_hits, u_if.broadcast); end
    endtask

`ifdef UDP_CHECKSUM_EN
    task automatic test_csum;
        build(16'h4444, 16'd1024, 16'd37, 37, 1'b0, 1'b1);
        send(8'd17, 1'b0, 37);
        n_vec++; if (csum_pulses != 0) begin n_err++; $display("FAIL csum_good pulses got %0d exp 0", csum_pulses); end
        build(16'h4444, 16'd1024, 16'd37, 37, 1'b0, 1'b1);
        tx_q[20] = tx_q[20] ^ 8'h10;
        send(8'd17, 1'b0, 37);
        n_vec++; if (csum_pulses != 1 || e_csum != 1) begin n_err++; $display("FAIL csum_bad pulses got %0d exp 1", csum_pulses); end
        n_vec++; if (csum_cyc != last_out_cyc + 1) begin n_err++; $display("FAIL csum_timing got %0d exp %0d", csum_cyc, last_out_cyc + 1); end
        n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL csum_forward bytes got %0d exp %0d", got_q.size(), exp_q.size()); end
        build(16'h4444, 16'd1024, 16'd37, 37, 1'b0, 1'b0);
        tx_q[20] = tx_q[20] ^ 8'h10;
        send(8'd17, 1'b0, 37);
        n_vec++; if (csum_pulses != 0) begin n_err++; $display("FAIL csum_zero pulses got %0d exp 0", csum_pulses); end
    endtask
`else
    task automatic test_csum;
        build(16'h4444, 16'd1024, 16'd37, 37, 1'b0, 1'b0);
        tx_q[6] = 8'h12;
        send(8'd17, 1'b0, 37);
        n_vec++; if (csum_pulses != 0) begin n_err++; $display("FAIL csum_off pulses got %0d exp 0", csum_pulses); end
        n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL csum_off_bytes got %0d exp %0d", got_q.size(), exp_q.size()); end
    endtask
`endif

    task automatic test_random;
        int len, ip_len, mode;
        bit bc;
        for (int it = 0; it < 12; it++) begin
            src_addr = $urandom;
            dst_addr = $urandom;
            bc   = 1'($urandom);
            mode = $urandom_range(0, 2);
            len  = $urandom_range(8, 120);
            if (mode == 2) begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(1501, 4000);
                build(16'($urandom), 16'($urandom), 16'(len), 20, 1'b0, 1'b0);
                ip_len = 20;
            end else begin
                build(16'($urandom), 16'($urandom), 16'(len), len, 1'b0, 1'b1);
                ip_len = (mode == 0) ? len + $urandom_range(0, 10) : $urandom_range(1, len - 1);
            end
            send(8'd17, bc, ip_len);
            n_vec++; if (got_q != exp_q) begin n_err++; $display("FAIL rand%0d_payload got %0d bytes exp %0d (len %0d ip %0d)", it, got_q.size(), exp_q.size(), len, ip_len); end
            n_vec++; if (rises != ((exp_q.size() > 0) ? 1 : 0)) begin n_err++; $display("FAIL rand%0d_rises got %0d", it, rises); end
            n_vec++; if (len_pulses != e_len || trunc_pulses != e_trunc || csum_pulses != e_csum) begin n_err++; $display("FAIL rand%0d_flags got %0d%0d%0d exp %0d%0d%0d", it, len_pulses, trunc_pulses, csum_pulses, e_len, e_trunc, e_csum); end
            n_vec++; if (u_if.udp_pkt_count !== exp_count) begin n_err++; $display("FAIL rand%0d_count got %0d exp %0d", it, u_if.udp_pkt_count, exp_count); end
            n_vec++; if (bcast_hits != (bc ? exp_q.size() : 0)) begin n_err++; $display("FAIL rand%0d_bcast got %0d", it, bcast_hits); end
        end
    endtask

    initial begin
        u_if.ip_rx_data   = 8'h00;
        u_if.ip_rx_active = 1'b0;
        u_if.ip_protocol  = 8'd0;
        u_if.ip_broadcast = 1'b0;
        src_addr = 32'hC0A8_0001;
        dst_addr = 32'hC0A8_00FF;
        u_if.ip_src_addr  = src_addr;
        u_if.ip_dst_addr  = dst_addr;
        test_reset();
        test_basic();
        test_padding();
        test_len_err();
        test_trunc();
        test_proto_bcast();
        test_csum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/udp_recv.md
Name: udp_recv

Overview:
- Upstream neighbour of the HPSDR port-1024 command decoder.
- Consumes the IP-layer payload byte stream and strips and validates the 8-byte UDP header.
- Presents the UDP payload bytes with udp_rx_active, to_port and broadcast, in the form the command decoder and the other port handlers expect.
- Sits between ip_recv and all UDP port consumers, in the rx_clock domain.

Parameters:
- MAX_UDP_LEN, 1500: largest accepted UDP length field in bytes, header included.
- UDP_PROTOCOL, 8'd17: IP protocol number that is accepted.

Ports:
- rx_clock  in  1  receive byte clock; one byte per cycle while ip_rx_active.
- reset_n  in  1  asynchronous, active-low reset.
- ip_rx_data  in  8  IP payload byte.
- ip_rx_active  in  1  high for every IP payload byte of one datagram; low ≥1 cycle between datagrams.
- ip_protocol  in  8  IP protocol field; stable while ip_rx_active.
- ip_broadcast  in  1  destination was a broadcast address; stable while ip_rx_active.
- ip_src_addr  in  32  IP source address (used only under the optional feature).
- ip_dst_addr  in  32  IP destination address (used only under the optional feature).
- udp_rx_data  out  8  UDP payload byte.
- udp_rx_active  out  1  high for exactly (length-8) consecutive cycles, one per payload byte.
- to_port  out  16  UDP destination port.
- from_port  out  16  UDP source port.
- udp_length  out  16  UDP length field of the current datagram.
- broadcast  out  1  registered copy of ip_broadcast for the current datagram.
- len_err  out  1  one-cycle pulse: length field <8 or >MAX_UDP_LEN.
- trunc_err  out  1  one-cycle pulse: ip_rx_active fell before the payload completed.
- csum_err  out  1  one-cycle pulse on a checksum mismatch (optional feature; tied 0 when disabled).
- udp_pkt_count  out  16  count of completed datagrams; wraps.

Behaviour:
- Reset: all outputs 0; state ST_IDLE; internal byte counter 0.
- ST_IDLE:
  - On ip_rx_active with ip_protocol==UDP_PROTOCOL: take the current byte as src port MSB, latch broadcast, byte counter=1, go to ST_HDR.
  - On ip_rx_active with any other protocol: go to ST_DRAIN with no outputs.
- ST_HDR, header byte layout:
  - bytes 1: from_port LSB.
  - bytes 2-3: to_port MSB then LSB.
  - bytes 4-5: udp_length MSB then LSB.
  - bytes 6-7: checksum MSB then LSB.
- ST_HDR, exit at byte 7:
  - length <8 or >MAX_UDP_LEN: pulse len_err; go to ST_DRAIN.
  - length==8: increment udp_pkt_count; go to ST_DRAIN; udp_rx_active never rises.
  - otherwise: load payload remaining counter = length-8 (16-bit); go to ST_PAYLOAD.
- Output timing:
  - to_port, from_port and udp_length are updated during the header.
  - They are valid before the first payload byte and held until the next datagram's header overwrites them.
- ST_PAYLOAD: each cycle with ip_rx_active, register the byte to udp_rx_data and set udp_rx_active=1 (latency 1 cycle) and decrement the remaining counter.
  - When the counter reaches 0: increment udp_pkt_count; go to ST_DRAIN.
  - On the next cycle udp_rx_active=0.
- Truncation: ip_rx_active low in ST_HDR or ST_PAYLOAD → pulse trunc_err, udp_rx_active=0 next cycle, go to ST_IDLE, no count increment.
- ST_DRAIN: discard bytes (IP padding, rejected datagrams); return to ST_IDLE when ip_rx_active is low.
- Guarantee: udp_rx_active is low ≥1 cycle between datagrams, so the consumer state machines reset to idle.
- udp_rx_data holds its last value when udp_rx_active is low.
- udp_pkt_count wraps 16'hFFFF→0.
- Async reset mid-packet: outputs clear immediately. After release the block waits in ST_IDLE; if ip_rx_active is still high, that partial datagram is treated as a new one from its current byte. Upstream guarantees reset only between datagrams in operation.

Optional Feature:
- Macro: UDP_CHECKSUM_EN.
- Defined:
  - Accumulate a 16-bit ones-complement sum over the pseudo-header (src addr, dst addr, 0, protocol, length), the header and the payload.
  - An odd trailing byte is padded with 0 low.
  - One cycle after the last payload byte, pulse csum_err if the final sum ≠16'hFFFF.
  - A received checksum of 16'h0000 means "not computed" → never an error.
  - Payload is still forwarded; csum_err is advisory.
- Undefined: no checksum logic; csum_err tied 0.

Test Plan:
1. Datagram protocol 17, src 0x1234, dst port 1024, length 68, payload 60 bytes 0x00..0x3B → to_port=1024, from_port=0x1234 before first byte; udp_rx_active high exactly 60 cycles, data 0x00..0x3B at 1-cycle latency; udp_pkt_count +1.
2. Length 20 with ip_rx_active lasting 46 bytes (padding) → 12 payload bytes forwarded, padding dropped, active low until next datagram.
3. Length field 6, then a separate datagram with length 1600 → len_err pulses once each, udp_rx_active never high, count unchanged.
4. ip_rx_active drops after payload byte 10 of a length 108 datagram → trunc_err pulse, udp_rx_active low next cycle, count unchanged; the following good datagram is received normally.
5. Protocol 6 (TCP) datagram → no outputs change; ip_broadcast=1 on a UDP datagram → broadcast=1 through its payload.
6. UDP_CHECKSUM_EN: correct checksum → no csum_err; one payload bit flipped → csum_err pulse 1 cycle after the last byte; checksum 0x0000 → no error.
